// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for a 4-register, 4-bit datapath.
// Sequences IDLE -> DECODE -> EXEC -> WB per instruction and drives an external register file.
module cpu_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [9:0] instr,
    output logic       instr_ready,
    output logic [1:0] reg_rd_addr1,
    output logic [1:0] reg_rd_addr2,
    input  logic [3:0] reg_rd_data1,
    input  logic [3:0] reg_rd_data2,
    output logic       reg_we,
    output logic [1:0] reg_wr_addr,
    output logic [3:0] reg_wr_data,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       done,
    output logic       halted
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [3:0] imm_q;
    logic [1:0] rd_addr1_q, rd_addr2_q;
    logic [3:0] a_q, b_q, r_q;
    logic       zero_q, carry_q;
    logic [3:0] alu_r;
    logic       alu_c;
    logic       accept;
    logic       unused_instr_bit;

    assign unused_instr_bit = instr[0];
    assign accept = (state_q == S_IDLE) && instr_valid;

    always_comb begin
        state_d = state_q;
        alu_r   = 4'h0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD:  {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                alu_r = a_q - b_q;
                alu_c = (a_q < b_q);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_LDI:  alu_r = imm_q;
            default: alu_r = 4'h0;
        endcase
        case (state_q)
            S_IDLE:   if (instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op_q == OP_NOP)       state_d = S_IDLE;
                else if (op_q == OP_HALT) state_d = S_HALT;
                else                      state_d = S_WB;
            end
            S_WB:     state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read addresses are loaded on acceptance, so they change only as DECODE begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= 2'd0;
            imm_q      <= 4'h0;
            rd_addr1_q <= 2'd0;
            rd_addr2_q <= 2'd0;
            a_q        <= 4'h0;
            b_q        <= 4'h0;
            r_q        <= 4'h0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= instr[9:7];
                rd_q       <= instr[6:5];
                imm_q      <= instr[4:1];
                rd_addr1_q <= instr[4:3];
                rd_addr2_q <= instr[2:1];
            end
            if (state_q == S_DECODE) begin
                a_q <= reg_rd_data1;
                b_q <= reg_rd_data2;
            end
            if (state_q == S_EXEC && op_q != OP_NOP && op_q != OP_HALT) begin
                r_q    <= alu_r;
                zero_q <= (alu_r == 4'h0);
                if (op_q != OP_LDI) carry_q <= alu_c;
            end
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign reg_rd_addr1 = rd_addr1_q;
    assign reg_rd_addr2 = rd_addr2_q;
    assign reg_we       = (state_q == S_WB);
    assign reg_wr_addr  = (state_q == S_WB) ? rd_q : 2'd0;
    assign reg_wr_data  = (state_q == S_WB) ? r_q : 4'h0;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign done         = (state_q == S_WB) ||
                          ((state_q == S_EXEC) && (op_q == OP_NOP || op_q == OP_HALT));
    assign halted       = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a small behavioural register file attached.
module tb_cpu_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [9:0] instr = 10'd0;
    logic       instr_ready;
    logic [1:0] reg_rd_addr1, reg_rd_addr2;
    logic [3:0] reg_rd_data1, reg_rd_data2;
    logic       reg_we;
    logic [1:0] reg_wr_addr;
    logic [3:0] reg_wr_data;
    logic       flag_zero, flag_carry, done, halted;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] rf [4];

    cpu_control_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .reg_rd_addr1(reg_rd_addr1), .reg_rd_addr2(reg_rd_addr2),
        .reg_rd_data1(reg_rd_data1), .reg_rd_data2(reg_rd_data2), .reg_we(reg_we),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .done(done), .halted(halted)
    );

    always #5 clk = ~clk;

    assign reg_rd_data1 = rf[reg_rd_addr1];
    assign reg_rd_data2 = rf[reg_rd_addr2];
    always @(posedge clk) if (reg_we) rf[reg_wr_addr] <= reg_wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 1'b0};
    endfunction

    function automatic logic [9:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b110, rd, imm, 1'b0};
    endfunction

    // Issue one instruction from IDLE and follow it cycle by cycle to retirement.
    task automatic run(input string tag, input logic [9:0] ins, input logic [3:0] exp_data,
                       input logic exp_z, input logic exp_c);
        logic [2:0] op;
        op = ins[9:7];
        @(negedge clk);
        chk({tag, ".ready"}, instr_ready, 1);
        instr_valid = 1'b1;
        instr = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 10'($urandom);
        chk({tag, ".busy"}, instr_ready, 0);
        chk({tag, ".rs1"}, reg_rd_addr1, ins[4:3]);
        chk({tag, ".rs2"}, reg_rd_addr2, ins[2:1]);
        @(negedge clk);
        chk({tag, ".exec_done"}, done, (op == 3'b000 || op == 3'b111));
        chk({tag, ".exec_we"}, reg_we, 0);
        if (op == 3'b000 || op == 3'b111) begin
            @(negedge clk);
            chk({tag, ".zero"}, flag_zero, exp_z);
            chk({tag, ".carry"}, flag_carry, exp_c);
            chk({tag, ".we"}, reg_we, 0);
            if (op == 3'b111) chk({tag, ".halted"}, halted, 1);
            else              chk({tag, ".ready_back"}, instr_ready, 1);
        end else begin
            @(negedge clk);
            chk({tag, ".wb_we"}, reg_we, 1);
            chk({tag, ".wb_addr"}, reg_wr_addr, ins[6:5]);
            chk({tag, ".wb_data"}, reg_wr_data, exp_data);
            chk({tag, ".wb_done"}, done, 1);
            chk({tag, ".zero"}, flag_zero, exp_z);
            chk({tag, ".carry"}, flag_carry, exp_c);
            @(negedge clk);
            chk({tag, ".ready_back"}, instr_ready, 1);
            chk({tag, ".we_off"}, reg_we, 0);
            chk({tag, ".data_off"}, reg_wr_data, 0);
        end
        $display("txn %s instr=%03h data=%h z=%b c=%b", tag, ins, reg_wr_data, flag_zero, flag_carry);
    endtask

    initial begin
        int accepts;
        int n_we;
        int we_cyc[3];
        logic [3:0] we_dat[3];
        int bad;

        rf[0] = 4'h0; rf[1] = 4'h0; rf[2] = 4'h0; rf[3] = 4'h0;
        #2;
        chk("rst.ready", instr_ready, 1);
        chk("rst.we", reg_we, 0);
        chk("rst.wr_addr", reg_wr_addr, 0);
        chk("rst.wr_data", reg_wr_data, 0);
        chk("rst.rd_addr", {reg_rd_addr1, reg_rd_addr2}, 0);
        chk("rst.flags", {flag_zero, flag_carry}, 0);
        chk("rst.done_halted", {done, halted}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("ldi_r1_9", ldi(2'd1, 4'h9), 4'h9, 0, 0);
        run("ldi_r2_7", ldi(2'd2, 4'h7), 4'h7, 0, 0);
        run("add_r3",   enc(3'b001, 2'd3, 2'd1, 2'd2), 4'h0, 1, 1);
        run("nop",      enc(3'b000, 2'd2, 2'd1, 2'd2), 4'h0, 1, 1);
        run("ldi_r1_3", ldi(2'd1, 4'h3), 4'h3, 0, 1);
        run("ldi_r2_5", ldi(2'd2, 4'h5), 4'h5, 0, 1);
        run("sub_r0",   enc(3'b010, 2'd0, 2'd1, 2'd2), 4'hE, 0, 1);
        run("xor_r0",   enc(3'b101, 2'd0, 2'd1, 2'd1), 4'h0, 1, 0);
        run("and_r0",   enc(3'b011, 2'd0, 2'd1, 2'd2), 4'h1, 0, 0);
        run("or_r3",    enc(3'b100, 2'd3, 2'd1, 2'd2), 4'h7, 0, 0);
        run("add_r1_self", enc(3'b001, 2'd1, 2'd1, 2'd1), 4'h6, 0, 0);

        // Streaming: valid held high, HALT words presented while busy must be ignored.
        accepts = 0;
        n_we = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (reg_we) begin
                if (n_we < 3) begin
                    we_cyc[n_we] = cyc;
                    we_dat[n_we] = reg_wr_data;
                end
                n_we++;
            end
            if (instr_ready && accepts < 3) begin
                instr_valid = 1'b1;
                instr = enc(3'b001, 2'd0, 2'd0, 2'd0);
                accepts++;
            end else begin
                instr_valid = (accepts < 3);
                instr = 10'b111_0000000;
            end
        end
        instr_valid = 1'b0;
        chk("stream.accepts", accepts, 3);
        chk("stream.we_count", n_we, 3);
        chk("stream.halted", halted, 0);
        if (n_we >= 3) begin
            chk("stream.gap1", we_cyc[1] - we_cyc[0], 4);
            chk("stream.gap2", we_cyc[2] - we_cyc[1], 4);
            chk("stream.data", {we_dat[0], we_dat[1], we_dat[2]}, 12'h248);
        end
        $display("txn stream accepts=%0d we_pulses=%0d", accepts, n_we);

        run("sub_r1_borrow", enc(3'b010, 2'd1, 2'd2, 2'd3), 4'hE, 0, 1);

        // Asynchronous reset in the middle of an ADD's EXEC cycle.
        @(negedge clk);
        instr_valid = 1'b1;
        instr = enc(3'b001, 2'd2, 2'd1, 2'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", instr_ready, 1);
        chk("midrst.we", reg_we, 0);
        chk("midrst.wr", {reg_wr_addr, reg_wr_data}, 0);
        chk("midrst.rd_addr", {reg_rd_addr1, reg_rd_addr2}, 0);
        chk("midrst.flags", {flag_zero, flag_carry}, 0);
        chk("midrst.done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (reg_we || done) bad++;
        end
        chk("midrst.no_retire", bad, 0);
        chk("midrst.r2_kept", rf[2], 4'h5);
        $display("txn midrst discarded ADD");

        run("ldi_r0_0", ldi(2'd0, 4'h0), 4'h0, 1, 0);
        run("halt", {3'b111, 7'd0}, 4'h0, 1, 0);
        bad = 0;
        instr_valid = 1'b1;
        instr = ldi(2'd1, 4'h5);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (!halted || instr_ready || reg_we || !flag_zero || done) bad++;
        end
        chk("halt.absorbing", bad, 0);
        rst_n = 1'b0;
        #1;
        chk("halt.rst_halted", halted, 0);
        chk("halt.rst_ready", instr_ready, 1);
        $display("txn halt held 10 cycles then reset");

        // First instruction accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        instr = ldi(2'd3, 4'hA);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("post_rst.accepted", instr_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst.wb_data", reg_wr_data, 4'hA);
        chk("post_rst.wb_we", reg_we, 1);
        $display("txn post_rst ldi r3=%h", reg_wr_data);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
